// File: rtl/load_store_unit_if.sv
// Bundle for the load/store unit: execute-stage request/response handshake
// plus the word-wide data-memory bus (AddrB / DataWrite / MemRW / DataB).
// The slave modport is the unit itself. The master modport is its environment,
// which is the execute stage together with the data memory.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] AddrB;
    logic [31:0] DataWrite;
    logic        MemRW;
    logic [31:0] DataB;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, DataB,
        input  req_ready, resp_valid, resp_err, resp_rdata, AddrB, DataWrite, MemRW
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, DataB,
        output req_ready, resp_valid, resp_err, resp_rdata, AddrB, DataWrite, MemRW
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the word-wide data-memory port.
// It accepts one load or store at a time and checks alignment, range and funct3.
// It extracts and extends sub-word loads, and it performs sub-word stores as a
// read-modify-write because the memory only writes whole words.
// Optional feature macro: LSU_SUBWORD_EN enables lb/lh/lbu/lhu/sb/sh.
// Without the macro, only lw/sw are legal.
module load_store_unit #(
    parameter int WORD_ADDR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ     = 3'd1,
        S_WRITE    = 3'd2,
        S_RESP     = 3'd3
`ifdef LSU_SUBWORD_EN
        ,
        S_RMW_READ = 3'd4
`endif
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        f3_legal;
    logic        misaligned;
    logic        out_of_range;
    logic        dec_err;
    logic        access_next;
    logic [31:0] word_index;
    logic [31:0] rdata_ext;

    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;
    logic [31:0] addr_b_q;
    logic [31:0] data_write_q;
    logic        mem_rw_q;

    assign word_index = {{(32-WORD_ADDR_W){1'b0}}, bus.req_addr[WORD_ADDR_W+1:2]};

    assign access_next = (state_next == S_READ)
`ifdef LSU_SUBWORD_EN
                      || (state_next == S_RMW_READ)
`endif
                      || (state_next == S_WRITE);

    // Classify the incoming request as legal or as an error (funct3, alignment, range)
    always_comb begin
        f3_legal     = 1'b0;
        misaligned   = 1'b0;
        out_of_range = |bus.req_addr[31:WORD_ADDR_W+2];
`ifdef LSU_SUBWORD_EN
        if (bus.req_we) begin
            f3_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                       (bus.req_funct3 == 3'b010);
        end else begin
            f3_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                       (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                       (bus.req_funct3 == 3'b101);
        end
`else
        f3_legal = (bus.req_funct3 == 3'b010);
`endif
        if ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) begin
            misaligned = 1'b1;
        end
        if ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00)) begin
            misaligned = 1'b1;
        end
        dec_err = !f3_legal || misaligned || out_of_range;
    end

    // Transaction sequencing: pick the access path at acceptance, then walk it to RESP
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (dec_err) begin
                        state_next = S_RESP;
                    end else if (!bus.req_we) begin
                        state_next = S_READ;
`ifdef LSU_SUBWORD_EN
                    end else if (bus.req_funct3 != 3'b010) begin
                        state_next = S_RMW_READ;
`endif
                    end else begin
                        state_next = S_WRITE;
                    end
                end
            end
            S_READ:     state_next = S_RESP;
`ifdef LSU_SUBWORD_EN
            S_RMW_READ: state_next = S_WRITE;
`endif
            S_WRITE:    state_next = S_RESP;
            S_RESP:     state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

`ifdef LSU_SUBWORD_EN
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic [15:0] lane_data;
    logic [31:0] merge_mask;
    logic [31:0] merge_ins;
    logic [31:0] merged_word;

    // Capture the request fields the sub-word paths need after acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_q <= 3'b000;
            lane_q   <= 2'b00;
            wdata_q  <= 16'h0000;
        end else if ((state == S_IDLE) && bus.req_valid) begin
            funct3_q <= bus.req_funct3;
            lane_q   <= bus.req_addr[1:0];
            wdata_q  <= bus.req_wdata[15:0];
        end
    end

    // Select the addressed lane of the read word and sign- or zero-extend it
    always_comb begin
        lane_data = 16'(bus.DataB >> {lane_q, 3'b000});
        case (funct3_q)
            3'b000:  rdata_ext = {{24{lane_data[7]}}, lane_data[7:0]};
            3'b001:  rdata_ext = {{16{lane_data[15]}}, lane_data};
            3'b100:  rdata_ext = {24'h000000, lane_data[7:0]};
            3'b101:  rdata_ext = {16'h0000, lane_data};
            default: rdata_ext = bus.DataB;
        endcase
    end

    // Overlay the store byte or half on the word read back during RMW_READ
    always_comb begin
        if (funct3_q[0]) begin
            merge_mask = 32'h0000_FFFF << {lane_q, 3'b000};
            merge_ins  = {16'h0000, wdata_q} << {lane_q, 3'b000};
        end else begin
            merge_mask = 32'h0000_00FF << {lane_q, 3'b000};
            merge_ins  = {24'h000000, wdata_q[7:0]} << {lane_q, 3'b000};
        end
        merged_word = (bus.DataB & ~merge_mask) | (merge_ins & merge_mask);
    end
`else
    assign rdata_ext = bus.DataB;
`endif

    // Registered response and memory-bus outputs, decoded from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            addr_b_q     <= '0;
            data_write_q <= '0;
            mem_rw_q     <= 1'b0;
        end else begin
            resp_valid_q <= (state_next == S_RESP);
            resp_err_q   <= (state == S_IDLE) && (state_next == S_RESP);

            if (state == S_READ) begin
                resp_rdata_q <= rdata_ext;
            end else if (state_next == S_RESP) begin
                resp_rdata_q <= '0;
            end

            mem_rw_q <= (state_next == S_WRITE);

            if (!access_next) begin
                addr_b_q <= '0;
            end else if (state == S_IDLE) begin
                addr_b_q <= word_index;
            end

            if (state_next != S_WRITE) begin
                data_write_q <= '0;
`ifdef LSU_SUBWORD_EN
            end else if (state == S_RMW_READ) begin
                data_write_q <= merged_word;
`endif
            end else begin
                data_write_q <= bus.req_wdata;
            end
        end
    end

    assign bus.req_ready  = (state == S_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.AddrB      = addr_b_q;
    assign bus.DataWrite  = data_write_q;
    assign bus.MemRW      = mem_rw_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit. It contains a 16-word data memory and a
// byte-level reference model of the RV32I load/store rules.
// The bench follows LSU_SUBWORD_EN the same way the design does.
module tb_load_store_unit;

    localparam int DEPTH = 16;
`ifdef LSU_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk;
    logic        rst;
    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    int          n_checks;
    int          n_fail;

    load_store_unit_if bus ();

    load_store_unit #(.WORD_ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write on the clock edge that ends MemRW
    assign bus.DataB = mem[bus.AddrB[3:0]];
    always @(posedge clk) begin
        if (bus.MemRW === 1'b1) mem[bus.AddrB[3:0]] <= bus.DataWrite;
    end

    // Absolute time limit so the run always ends
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference model: legality, load result, merged store word and latency, computed byte by byte
    function automatic void model_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                      input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                                      output int lat, output logic [31:0] new_word);
        int         size;
        bit         legal;
        bit         is_signed;
        int         off;
        logic [31:0] w;
        logic [7:0] b [4];
        size = 4; legal = 1'b0; is_signed = 1'b0;
        case (f3)
            3'd0: begin size = 1; legal = SUBWORD; is_signed = 1'b1; end
            3'd1: begin size = 2; legal = SUBWORD; is_signed = 1'b1; end
            3'd2: begin size = 4; legal = 1'b1; end
            3'd4: begin size = 1; legal = SUBWORD && !we; end
            3'd5: begin size = 2; legal = SUBWORD && !we; end
            default: legal = 1'b0;
        endcase
        err = !legal || ((addr % size) != 0) || (addr >= 4 * DEPTH);
        rdata = 32'h0; new_word = 32'h0; lat = 1;
        if (err) return;
        off = int'(addr % 4);
        w = ref_mem[addr[5:2]];
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        if (!we) begin
            lat = 2;
            for (int i = 0; i < size; i++) rdata[8*i +: 8] = b[off+i];
            if (is_signed && size < 4 && rdata[8*size-1]) begin
                for (int i = size; i < 4; i++) rdata[8*i +: 8] = 8'hFF;
            end
        end else begin
            lat = (size == 4) ? 2 : 3;
            for (int i = 0; i < size; i++) b[off+i] = wdata[8*i +: 8];
            new_word = {b[3], b[2], b[1], b[0]};
        end
    endfunction

    // Drive one request and record everything seen until one cycle after its response
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic o_err, output logic [31:0] o_rdata, output int o_lat, output int o_writes,
                           output logic [31:0] o_waddr, output logic [31:0] o_wdata, output logic [31:0] o_addrb1,
                           output logic o_pulse_after, output logic [31:0] o_rdata_after,
                           output logic o_ready_busy, output logic o_timeout);
        int waits;
        o_err = 1'bx; o_rdata = 'x; o_lat = 0; o_writes = 0; o_waddr = 'x; o_wdata = 'x;
        o_addrb1 = 'x; o_pulse_after = 1'bx; o_rdata_after = 'x; o_ready_busy = 1'b0; o_timeout = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wdata;
        waits = 0;
        while (bus.req_ready !== 1'b1 && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        if (bus.req_ready !== 1'b1) begin
            o_timeout = 1'b1;
            bus.req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0; bus.req_we = 1'($urandom); bus.req_funct3 = 3'($urandom);
            bus.req_addr = $urandom; bus.req_wdata = $urandom;
            while (o_lat < 10) begin
                @(negedge clk);
                o_lat++;
                if (o_lat == 1) o_addrb1 = bus.AddrB;
                if (bus.MemRW === 1'b1) begin
                    o_writes++; o_waddr = bus.AddrB; o_wdata = bus.DataWrite;
                end
                if (bus.req_ready !== 1'b0) o_ready_busy = 1'b1;
                if (bus.resp_valid === 1'b1) break;
            end
            if (bus.resp_valid !== 1'b1) begin
                o_timeout = 1'b1;
            end else begin
                o_err = bus.resp_err; o_rdata = bus.resp_rdata;
                @(negedge clk);
                o_pulse_after = bus.resp_valid; o_rdata_after = bus.resp_rdata;
            end
        end
    endtask

    // Reset for two cycles, then idle: every output quiet and the unit ready
    task automatic test_reset();
        int rw_seen;
        int resp_seen;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset resp_valid: got %b want 0", bus.resp_valid); end
        n_checks++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset resp_err: got %b want 0", bus.resp_err); end
        n_checks++; if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset resp_rdata: got %h want 0", bus.resp_rdata); end
        n_checks++; if (bus.AddrB !== 32'h0) begin n_fail++; $display("[TB] FAIL reset AddrB: got %h want 0", bus.AddrB); end
        n_checks++; if (bus.DataWrite !== 32'h0) begin n_fail++; $display("[TB] FAIL reset DataWrite: got %h want 0", bus.DataWrite); end
        n_checks++; if (bus.MemRW !== 1'b0) begin n_fail++; $display("[TB] FAIL reset MemRW: got %b want 0", bus.MemRW); end
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset req_ready: got %b want 1", bus.req_ready); end
        rw_seen = 0; resp_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.MemRW !== 1'b0) rw_seen++;
            if (bus.resp_valid !== 1'b0) resp_seen++;
        end
        n_checks++; if (rw_seen != 0) begin n_fail++; $display("[TB] FAIL idle MemRW: got %0d active cycles want 0", rw_seen); end
        n_checks++; if (resp_seen != 0) begin n_fail++; $display("[TB] FAIL idle resp_valid: got %0d pulses want 0", resp_seen); end
    endtask

    // Scenario from the plan: sw/lw, sb over a known word, sb readback, sh/lh and the error cases
    task automatic test_directed();
        txn_t        tbl [$];
        logic        e;
        logic [31:0] rd;
        logic [31:0] nw;
        int          lat;
        logic        o_err, o_pulse, o_rb, o_to;
        logic [31:0] o_rd, o_wa, o_wd, o_ab, o_rda;
        int          o_lat, o_wr;
        tbl.push_back('{1'b1, 3'b010, 32'h8, 32'hDEADBEEF});
        tbl.push_back('{1'b0, 3'b010, 32'h8, 32'h0});
        tbl.push_back('{1'b1, 3'b000, 32'h9, 32'h12345680});
        tbl.push_back('{1'b0, 3'b000, 32'h9, 32'h0});
        tbl.push_back('{1'b0, 3'b100, 32'h9, 32'h0});
        tbl.push_back('{1'b1, 3'b001, 32'hA, 32'hFFFF1234});
        tbl.push_back('{1'b0, 3'b001, 32'hA, 32'h0});
        tbl.push_back('{1'b0, 3'b010, 32'h6, 32'h0});
        tbl.push_back('{1'b1, 3'b010, 32'h40, 32'hCAFEF00D});
        tbl.push_back('{1'b0, 3'b000, 32'h0, 32'h0});
        foreach (tbl[i]) begin
            model_txn(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, e, rd, lat, nw);
            run_txn(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
                    o_err, o_rd, o_lat, o_wr, o_wa, o_wd, o_ab, o_pulse, o_rda, o_rb, o_to);
            n_checks++;
            if (o_to) begin n_fail++; $display("[TB] FAIL dir%0d timeout: no handshake within bound", i); continue; end
            n_checks++; if (o_err !== e) begin n_fail++; $display("[TB] FAIL dir%0d err: got %b want %b", i, o_err, e); end
            n_checks++; if (o_lat != lat) begin n_fail++; $display("[TB] FAIL dir%0d latency: got %0d want %0d", i, o_lat, lat); end
            n_checks++; if (o_rd !== rd) begin n_fail++; $display("[TB] FAIL dir%0d rdata: got %h want %h", i, o_rd, rd); end
            n_checks++; if (o_wr != ((!e && tbl[i].we) ? 1 : 0)) begin n_fail++; $display("[TB] FAIL dir%0d write count: got %0d want %0d", i, o_wr, (!e && tbl[i].we) ? 1 : 0); end
            n_checks++; if (o_pulse !== 1'b0) begin n_fail++; $display("[TB] FAIL dir%0d resp width: got %b after pulse want 0", i, o_pulse); end
            if (!e && tbl[i].we) ref_mem[tbl[i].addr[5:2]] = nw;
            case (i)
                0: begin
                    n_checks++; if (o_wa !== 32'd2) begin n_fail++; $display("[TB] FAIL sw AddrB: got %h want 2", o_wa); end
                    n_checks++; if (o_wd !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL sw DataWrite: got %h want deadbeef", o_wd); end
                end
                1: begin
                    n_checks++; if (o_rd !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL lw result: got %h want deadbeef", o_rd); end
                end
`ifdef LSU_SUBWORD_EN
                2: begin
                    n_checks++; if (o_wd !== 32'hDEAD80EF) begin n_fail++; $display("[TB] FAIL sb merge: got %h want dead80ef", o_wd); end
                    n_checks++; if (o_lat != 3) begin n_fail++; $display("[TB] FAIL sb latency: got %0d want 3", o_lat); end
                end
                3: begin
                    n_checks++; if (o_rd !== 32'hFFFFFF80) begin n_fail++; $display("[TB] FAIL lb sign: got %h want ffffff80", o_rd); end
                end
                4: begin
                    n_checks++; if (o_rd !== 32'h00000080) begin n_fail++; $display("[TB] FAIL lbu zero: got %h want 00000080", o_rd); end
                end
                6: begin
                    n_checks++; if (o_rd !== 32'h00001234) begin n_fail++; $display("[TB] FAIL lh result: got %h want 00001234", o_rd); end
                end
`else
                9: begin
                    n_checks++; if (o_err !== 1'b1) begin n_fail++; $display("[TB] FAIL lb without subword: got err %b want 1", o_err); end
                end
`endif
                7, 8: begin
                    n_checks++; if (o_err !== 1'b1 || o_lat != 1) begin n_fail++; $display("[TB] FAIL error case %0d: got err %b lat %0d want err 1 lat 1", i, o_err, o_lat); end
                    n_checks++; if (o_wr != 0) begin n_fail++; $display("[TB] FAIL error case %0d MemRW: got %0d writes want 0", i, o_wr); end
                end
                default: ;
            endcase
        end
    endtask

    // Random mix of loads and stores, including illegal funct3, misaligned and out-of-range addresses
    task automatic test_random();
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata;
        logic        e;
        logic [31:0] rd, nw;
        int          lat;
        logic        o_err, o_pulse, o_rb, o_to;
        logic [31:0] o_rd, o_wa, o_wd, o_ab, o_rda;
        int          o_lat, o_wr;
        logic [2:0]  legal_f3 [5];
        legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 3) != 0) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
            addr = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 2) == 0) addr[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) addr = addr | (32'h1 << $urandom_range(6, 31));
            wdata = $urandom;
            model_txn(we, f3, addr, wdata, e, rd, lat, nw);
            run_txn(we, f3, addr, wdata, o_err, o_rd, o_lat, o_wr, o_wa, o_wd, o_ab, o_pulse, o_rda, o_rb, o_to);
            n_checks++;
            if (o_to) begin n_fail++; $display("[TB] FAIL rnd%0d timeout: no handshake within bound", n); continue; end
            n_checks++; if (o_err !== e) begin n_fail++; $display("[TB] FAIL rnd%0d err we=%b f3=%0d addr=%h: got %b want %b", n, we, f3, addr, o_err, e); end
            n_checks++; if (o_lat != lat) begin n_fail++; $display("[TB] FAIL rnd%0d latency: got %0d want %0d", n, o_lat, lat); end
            n_checks++; if (o_rd !== rd) begin n_fail++; $display("[TB] FAIL rnd%0d rdata f3=%0d addr=%h: got %h want %h", n, f3, addr, o_rd, rd); end
            n_checks++; if (o_rda !== rd) begin n_fail++; $display("[TB] FAIL rnd%0d rdata hold: got %h want %h", n, o_rda, rd); end
            n_checks++; if (o_pulse !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd%0d resp width: got %b after pulse want 0", n, o_pulse); end
            n_checks++; if (o_rb !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd%0d req_ready while busy: got %b want 0", n, o_rb); end
            n_checks++; if (o_ab !== (e ? 32'h0 : {28'h0, addr[5:2]})) begin n_fail++; $display("[TB] FAIL rnd%0d AddrB: got %h want %h", n, o_ab, e ? 32'h0 : {28'h0, addr[5:2]}); end
            n_checks++; if (o_wr != ((!e && we) ? 1 : 0)) begin n_fail++; $display("[TB] FAIL rnd%0d write count: got %0d want %0d", n, o_wr, (!e && we) ? 1 : 0); end
            if (!e && we) begin
                n_checks++; if (o_wa !== {28'h0, addr[5:2]} || o_wd !== nw) begin n_fail++; $display("[TB] FAIL rnd%0d write: got [%h]=%h want [%h]=%h", n, o_wa, o_wd, {28'h0, addr[5:2]}, nw); end
                ref_mem[addr[5:2]] = nw;
            end
        end
    endtask

    // Requests held valid back to back: lw is accepted every third cycle, one response each
    task automatic test_back_to_back();
        logic [31:0] a, want, rd;
        int          cyc;
        bit          got;
        @(negedge clk);
        a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = a;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b%0d ready: got %b want 1", k, bus.req_ready); end
            want = ref_mem[a[5:2]];
            @(posedge clk);
            #1;
            a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            bus.req_addr = a;
            cyc = 0; got = 1'b0; rd = 'x;
            while (cyc < 10 && bus.req_ready !== 1'b1) begin
                @(negedge clk);
                cyc++;
                if (bus.resp_valid === 1'b1) begin got = 1'b1; rd = bus.resp_rdata; end
            end
            n_checks++; if (!got || rd !== want) begin n_fail++; $display("[TB] FAIL b2b%0d response: got valid %b data %h want data %h", k, got, rd, want); end
            n_checks++; if (cyc != 3) begin n_fail++; $display("[TB] FAIL b2b%0d spacing: got %0d cycles want 3", k, cyc); end
        end
        bus.req_valid = 1'b0;
    endtask

    // Reset during the read phase of a store (RMW_READ) or a load: no write, no response
    task automatic test_reset_mid();
        int          rw_seen;
        int          resp_seen;
        logic [31:0] wd;
        wd = $urandom;
        @(negedge clk);
`ifdef LSU_SUBWORD_EN
        bus.req_we = 1'b1; bus.req_funct3 = 3'b000; bus.req_addr = 32'h5; bus.req_wdata = wd;
`else
        bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h4; bus.req_wdata = wd;
`endif
        bus.req_valid = 1'b1;
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset ready before: got %b want 1", bus.req_ready); end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        rw_seen = 0; resp_seen = 0;
        @(negedge clk);
        if (bus.MemRW !== 1'b0) rw_seen++;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.MemRW !== 1'b0) rw_seen++;
            if (bus.resp_valid !== 1'b0) resp_seen++;
        end
        n_checks++; if (rw_seen != 0) begin n_fail++; $display("[TB] FAIL midreset MemRW: got %0d active cycles want 0", rw_seen); end
        n_checks++; if (resp_seen != 0) begin n_fail++; $display("[TB] FAIL midreset resp_valid: got %0d pulses want 0", resp_seen); end
        n_checks++; if (mem[1] !== ref_mem[1]) begin n_fail++; $display("[TB] FAIL midreset memory word: got %h want %h", mem[1], ref_mem[1]); end
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset ready after: got %b want 1", bus.req_ready); end
    endtask

    // Memory contents must equal the reference image built from accepted stores
    task automatic test_memory();
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (mem[i] !== ref_mem[i]) begin n_fail++; $display("[TB] FAIL memory word %0d: got %h want %h", i, mem[i], ref_mem[i]); end
        end
    endtask

    // Test sequence
    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        $display("[TB] load_store_unit bench, subword support = %0d", SUBWORD);
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_memory();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory port: accepts one load or store per transaction from the RV32I execute stage and drives the word-wide data memory's AddrB / DataWrite / MemRW / DataB interface. Handles byte/halfword extraction with sign or zero extension on loads, and read-modify-write on sub-word stores, because the memory only writes full words. Checks alignment and range, and returns one response per accepted request.

## Interface
- WORD_ADDR_W, 4, width of the memory word index; the memory holds 2^WORD_ADDR_W words.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: loads 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores 000 sb, 001 sh, 010 sw.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/half used for sb/sh.
- resp_valid  out  1  one-cycle response pulse.
- resp_err  out  1  valid with resp_valid: misaligned, out-of-range or illegal funct3; no memory write occurred.
- resp_rdata  out  32  load result; 0 for stores and errors; held until the next response.
- AddrB  out  32  memory word index = req_addr[WORD_ADDR_W+1:2], zero-extended.
- DataWrite  out  32  word written to memory.
- MemRW  out  1  1 = write on this clock edge, 0 = combinational read.
- DataB  in  32  memory read data, valid in the same cycle as AddrB when MemRW = 0.

## Operation
- States: IDLE, READ, RMW_READ, WRITE, RESP.
- IDLE: req_ready = 1. On req_valid, latch all request fields and decode:
  - error (misaligned: lh/lhu/sh with addr[0] = 1, or lw/sw with addr[1:0] != 0; out of range: req_addr[31:WORD_ADDR_W+2] != 0; illegal funct3) -> RESP with err set.
  - load -> READ.
  - sw -> WRITE.
  - sb/sh -> RMW_READ.
- READ: MemRW = 0. Capture DataB, select the lane given by addr[1:0], then:
  - lb/lh: sign-extend.
  - lbu/lhu: zero-extend.
  - lw: whole word.
  - Go to RESP.
- RMW_READ: MemRW = 0. Capture DataB and replace the addressed byte (sb) or half (sh) with req_wdata[7:0] or req_wdata[15:0]. Go to WRITE.
- WRITE: MemRW = 1 for exactly this cycle; DataWrite = full word (sw) or merged word (sb/sh). Go to RESP.
- RESP: resp_valid = 1 for one cycle. Go to IDLE.
- Outside READ, RMW_READ and WRITE: AddrB = 0, DataWrite = 0, MemRW = 0.
- A request arriving while req_ready = 0 is not accepted; the requester holds it until req_ready = 1.

## Timing
- Reset (sampled at a clk edge): state = IDLE; resp_valid, resp_err, resp_rdata, AddrB, DataWrite and MemRW all 0; req_ready = 1 in the following cycle.
- Reset mid-transaction aborts it: no response is produced, and MemRW drops to 0 in the same edge, so no write occurs afterward.
- Latency, counting the acceptance edge as cycle 0, to resp_valid:
  - error: cycle 1.
  - load and sw: cycle 2.
  - sb/sh: cycle 3.
- Throughput: one transaction in flight. The next request can be accepted in the cycle after RESP (IDLE).
- AddrB, DataWrite and MemRW are registered state decodes: glitch-free, and stable for the whole access cycle.
- Memory writes on the clk edge that ends WRITE.

## Configuration
- LSU_SUBWORD_EN defined: full lb/lh/lbu/lhu/sb/sh support as above, including the RMW_READ state.
- Not defined: only lw/sw are legal. Every other funct3 returns resp_err at cycle 1 with no memory access, and RMW_READ plus the extension/merge logic are removed.

## Test plan
- Reset then idle: rst 1 for 2 cycles -> all outputs 0, req_ready = 1, MemRW never 1.
- sw 0xDEADBEEF to addr 0x8, then lw from 0x8:
  - sw: WRITE cycle drives AddrB = 2, MemRW = 1; resp_valid at cycle 2, err = 0.
  - lw: resp_rdata = 0xDEADBEEF at cycle 2.
- sb 0x80 to addr 0x9 over word 0xDEADBEEF:
  - RMW_READ, then WRITE with DataWrite = 0xDEAD80EF; resp at cycle 3.
  - lb from 0x9 -> 0xFFFFFF80; lbu from 0x9 -> 0x00000080.
- sh 0x1234 to 0xA, then lh from 0xA -> 0x00001234.
- Errors, each with resp_err = 1 at cycle 1, MemRW = 0 throughout:
  - lw at 0x6 (misaligned).
  - sw at 0x40 with WORD_ADDR_W = 4 (out of range).
- Reset mid-transaction: rst asserted during RMW_READ of an sb -> no MemRW pulse, no resp_valid, memory word unchanged.
- Without LSU_SUBWORD_EN: lb from 0x0 -> resp_err = 1 at cycle 1.
